// File: rtl/seg_scan_monitor.sv
// seg_scan_monitor
// Reads back a multiplexed active-low seven-segment bus and recovers the
// 4-bit character code shown on each digit.
// The block watches the anode scan and waits for the (an, seg) pair to stay
// stable for SETTLE_CYCLES samples. It then captures the pattern into that
// digit's slot.
//
// Ports
//   clk, rst_n   clock and asynchronous active-low reset
//   an           anode enables, active-low; a valid scan has exactly one bit low
//   seg          segments, active-low, bit order {g,f,e,d,c,b,a}
//   err_clr      synchronous clear of err_sticky
//   char_codes   recovered code per digit; digit i is in [4i+3:4i]
//   digit_valid  last capture of digit i was a recognised character
//   digit_blank  last capture of digit i was all-off
//   frame_done   one-cycle pulse once every digit has been captured
//   err_sticky   an unrecognised pattern was captured since reset / err_clr

// Per-digit capture slot: code and flags, loaded on the capture strobe.
module seg_scan_slot (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cap_i,
  input  logic [3:0] code_i,
  input  logic       valid_i,
  input  logic       blank_i,
  output logic [3:0] code_o,
  output logic       valid_o,
  output logic       blank_o
);
  logic [3:0] code_q;
  logic       valid_q, blank_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      blank_q <= 1'b0;
    end else if (cap_i) begin
      code_q  <= code_i;
      valid_q <= valid_i;
      blank_q <= blank_i;
    end
  end

  assign code_o  = code_q;
  assign valid_o = valid_q;
  assign blank_o = blank_q;
endmodule

module seg_scan_monitor #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] char_codes,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_done,
  output logic                    err_sticky
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_e;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_set;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;

  logic [NUM_DIGITS-1:0]   an_low;
  logic                    an_onehot, same, capture;
  logic [3:0]              dec_code;
  logic                    dec_valid, dec_blank;

  // Decisions compare the incoming pair against the registered one, so a
  // capture only happens once the pair has been sampled identically
  // SETTLE_CYCLES+1 times in a row.
  assign an_low    = ~an;
  assign an_onehot = (an_low != '0) && ((an_low & (an_low - NUM_DIGITS'(1))) == '0);
  assign same      = (an == an_q) && (seg == seg_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!an_onehot) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (!same) begin
      state_d = S_SETTLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            capture = 1'b1;
            state_d = S_HELD;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        // Keep counting while held but stop at the top so it never wraps.
        S_HELD:  if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Reverse map of the character decoder. 7'h12 is both 5 and S; it always
  // reads back as 5, so code 14 never appears.
  always_comb begin
    dec_code  = '0;
    dec_valid = 1'b1;
    dec_blank = 1'b0;
    case (seg_q)
      7'h40: dec_code = 4'd0;
      7'h79: dec_code = 4'd1;
      7'h24: dec_code = 4'd2;
      7'h30: dec_code = 4'd3;
      7'h19: dec_code = 4'd4;
      7'h12: dec_code = 4'd5;
      7'h02: dec_code = 4'd6;
      7'h78: dec_code = 4'd7;
      7'h00: dec_code = 4'd8;
      7'h10: dec_code = 4'd9;
      7'h06: dec_code = 4'd10;
      7'h47: dec_code = 4'd11;
      7'h46: dec_code = 4'd12;
      7'h0C: dec_code = 4'd13;
      7'h3F: dec_code = 4'd15;
      7'h7F: begin
        dec_valid = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_valid = 1'b0;
    endcase
  end

  // A capture marks its slot in the seen mask. The capture that completes
  // the mask fires frame_done and starts a new frame.
  always_comb begin
    seen_set = seen_q | (~an_q & {NUM_DIGITS{capture}});
    frame_d  = capture && (&seen_set);
    seen_d   = frame_d ? '0 : seen_set;
    // An invalid capture beats a simultaneous clear.
    if (capture && !dec_valid && !dec_blank) err_d = 1'b1;
    else if (err_clr)                        err_d = 1'b0;
    else                                     err_d = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q    <= '1;
      seg_q   <= 7'h7F;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      seen_q  <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      an_q    <= an;
      seg_q   <= seg;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_slot
    seg_scan_slot u_slot (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .cap_i   (capture & ~an_q[i]),
      .code_i  (dec_code),
      .valid_i (dec_valid),
      .blank_i (dec_blank),
      .code_o  (char_codes[4*i +: 4]),
      .valid_o (digit_valid[i]),
      .blank_o (digit_blank[i])
    );
  end

  assign frame_done = frame_q;
  assign err_sticky = err_q;
endmodule

// File: tb/tb_seg_scan_monitor.sv
module tb_seg_scan_monitor;
  localparam int ND = 4;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [ND-1:0] an;
  logic [6:0]    seg;
  logic          err_clr;
  logic [4*ND-1:0] char_codes;
  logic [ND-1:0] digit_valid, digit_blank;
  logic          frame_done, err_sticky;

  seg_scan_monitor #(.NUM_DIGITS(ND), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .seg(seg), .err_clr(err_clr),
    .char_codes(char_codes), .digit_valid(digit_valid), .digit_blank(digit_blank),
    .frame_done(frame_done), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;

  // Character table indexed by code; 8'hFF marks the code with no pattern.
  localparam logic [7:0] TBL [16] = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h19, 8'h12, 8'h02, 8'h78,
                                      8'h00, 8'h10, 8'h06, 8'h47, 8'h46, 8'h0C, 8'hFF, 8'h3F};

  // Reference model: a capture happens when a one-hot-low pair has been
  // sampled on exactly S+1 consecutive edges.
  logic [ND-1:0]   m_an;
  logic [6:0]      m_seg;
  int              m_run;
  logic [4*ND-1:0] m_codes;
  logic [ND-1:0]   m_vld, m_blk, m_seen;
  logic            m_frame, m_err;

  // Returns the code, -1 for blank, -2 for unrecognised.
  function automatic int ref_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (TBL[i] == {1'b0, p}) return i;
    if (p == 7'h7F) return -1;
    return -2;
  endfunction

  task automatic model_reset();
    m_an = '1; m_seg = 7'h7F; m_run = 0;
    m_codes = '0; m_vld = '0; m_blk = '0; m_seen = '0; m_frame = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic [ND-1:0] a, input logic [6:0] s, input logic clr);
    int d, c;
    logic inv;
    if (a == m_an && s == m_seg) m_run++;
    else m_run = 1;
    m_an = a; m_seg = s;
    m_frame = 1'b0;
    inv = 1'b0;
    if ($countones(~a) == 1 && m_run == S + 1) begin
      d = 0;
      for (int i = 0; i < ND; i++) if (!a[i]) d = i;
      c = ref_decode(s);
      m_codes[4*d +: 4] = (c >= 0) ? 4'(c) : 4'd0;
      m_vld[d] = (c >= 0);
      m_blk[d] = (c == -1);
      inv = (c == -2);
      m_seen[d] = 1'b1;
      if (&m_seen) begin m_frame = 1'b1; m_seen = '0; end
    end
    if (inv) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return 32'({char_codes, digit_valid, digit_blank, frame_done, err_sticky});
  endfunction

  // One clock: drive at the falling edge, update the model on the rising
  // edge, compare 1 time unit later, and return at the next falling edge.
  task automatic step(input logic [ND-1:0] a, input logic [6:0] s, input logic c);
    an = a; seg = s; err_clr = c;
    @(posedge clk);
    model_edge(a, s, c);
    #1;
    chk("model", dut_vec(), 32'({m_codes, m_vld, m_blk, m_frame, m_err}));
    if (frame_done === 1'b1) frame_cnt++;
    @(negedge clk);
  endtask

  typedef struct {
    logic [ND-1:0]   an;
    logic [6:0]      seg;
    int              cyc;
    logic            clr;
    logic [4*ND-1:0] codes;
    logic [ND-1:0]   vld;
    logic [ND-1:0]   blk;
    int              frames;
    logic            err;
  } vec_t;

  vec_t tv [17];

  initial begin
    tv[0]  = '{4'b1110, 7'h40, 10, 1'b0, 16'h0000, 4'b0001, 4'b0000, 0, 1'b0};
    tv[1]  = '{4'b1101, 7'h79, 10, 1'b0, 16'h0010, 4'b0011, 4'b0000, 0, 1'b0};
    tv[2]  = '{4'b1011, 7'h24, 10, 1'b0, 16'h0210, 4'b0111, 4'b0000, 0, 1'b0};
    tv[3]  = '{4'b0111, 7'h30, 10, 1'b0, 16'h3210, 4'b1111, 4'b0000, 1, 1'b0};
    tv[4]  = '{4'b1110, 7'h06,  4, 1'b0, 16'h3210, 4'b1111, 4'b0000, 0, 1'b0};
    tv[5]  = '{4'b1101, 7'h79,  4, 1'b0, 16'h3210, 4'b1111, 4'b0000, 0, 1'b0};
    tv[6]  = '{4'b1110, 7'h06,  5, 1'b0, 16'h321A, 4'b1111, 4'b0000, 0, 1'b0};
    tv[7]  = '{4'b1101, 7'h12,  6, 1'b0, 16'h325A, 4'b1111, 4'b0000, 0, 1'b0};
    tv[8]  = '{4'b1011, 7'h7F,  6, 1'b0, 16'h305A, 4'b1011, 4'b0100, 0, 1'b0};
    tv[9]  = '{4'b0111, 7'h3F,  6, 1'b0, 16'hF05A, 4'b1011, 4'b0100, 1, 1'b0};
    tv[10] = '{4'b1110, 7'h55,  6, 1'b0, 16'hF050, 4'b1010, 4'b0100, 0, 1'b1};
    tv[11] = '{4'b1101, 7'h02,  6, 1'b1, 16'hF060, 4'b1010, 4'b0100, 0, 1'b0};
    tv[12] = '{4'b1100, 7'h40, 20, 1'b0, 16'hF060, 4'b1010, 4'b0100, 0, 1'b0};
    tv[13] = '{4'b1111, 7'h40, 20, 1'b0, 16'hF060, 4'b1010, 4'b0100, 0, 1'b0};
    tv[14] = '{4'b1011, 7'h47,  6, 1'b0, 16'hFB60, 4'b1110, 4'b0000, 0, 1'b0};
    tv[15] = '{4'b1011, 7'h46,  6, 1'b0, 16'hFC60, 4'b1110, 4'b0000, 0, 1'b0};
    tv[16] = '{4'b0111, 7'h0C,  6, 1'b0, 16'hDC60, 4'b1110, 4'b0000, 1, 1'b0};

    rst_n = 1'b0; an = '1; seg = 7'h7F; err_clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", dut_vec(), 32'h0);
    rst_n = 1'b1;

    // Table-driven dwells.
    for (int v = 0; v < 17; v++) begin
      frame_cnt = 0;
      for (int k = 0; k < tv[v].cyc; k++)
        step(tv[v].an, tv[v].seg, (k == 0) ? tv[v].clr : 1'b0);
      chk($sformatf("vec%0d_out", v), 32'({char_codes, digit_valid, digit_blank, err_sticky}),
          32'({tv[v].codes, tv[v].vld, tv[v].blk, tv[v].err}));
      chk($sformatf("vec%0d_frames", v), 32'(frame_cnt), 32'(tv[v].frames));
    end

    // err_clr on the same edge as an invalid capture: the set wins.
    for (int k = 0; k < S; k++) step(4'b1110, 7'h55, 1'b0);
    step(4'b1110, 7'h55, 1'b1);
    chk("clr_vs_set_err", 32'(err_sticky), 32'd1);
    chk("clr_vs_set_vld0", 32'(digit_valid[0]), 32'd0);
    step(4'b1111, 7'h7F, 1'b1);
    chk("clr_alone", 32'(err_sticky), 32'd0);

    // Reset in the middle of a dwell discards the partial count.
    step(4'b1101, 7'h79, 1'b0);
    step(4'b1101, 7'h79, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", dut_vec(), 32'h0);
    @(posedge clk);
    #1;
    chk("mid_reset_hold", dut_vec(), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < S; k++) step(4'b1101, 7'h79, 1'b0);
    chk("post_reset_no_cap", 32'(digit_valid), 32'd0);
    step(4'b1101, 7'h79, 1'b0);
    chk("post_reset_cap", 32'({char_codes, digit_valid}), 32'({16'h0010, 4'b0010}));

    // Randomised dwells against the reference model.
    for (int n = 0; n < 300; n++) begin
      logic [ND-1:0] a;
      logic [6:0]    s;
      int            cyc;
      int            idx;
      if ($urandom_range(0, 9) < 8) a = ~(ND'(1) << $urandom_range(0, ND - 1));
      else                          a = ND'($urandom);
      idx = $urandom_range(0, 17);
      if (idx < 16 && idx != 14) s = TBL[idx][6:0];
      else if (idx == 16)        s = 7'h7F;
      else                       s = 7'($urandom);
      cyc = $urandom_range(1, 8);
      for (int k = 0; k < cyc; k++) step(a, s, ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
